// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - trace entry layout shared by the capture block; TRACE_TSTAMP_EN adds a timestamp field
package trace_pkg;

    localparam int TR_ALU_LSB   = 0;
    localparam int TR_ALU_MSB   = 31;
    localparam int TR_INSTR_LSB = 32;
    localparam int TR_INSTR_MSB = 63;
    localparam int TR_PC_LSB    = 64;
    localparam int TR_PC_MSB    = 95;
    localparam int TR_RW_BIT    = 96;
`ifdef TRACE_TSTAMP_EN
    localparam int TR_TS_LSB    = 97;
    localparam int TR_TS_MSB    = 128;
    localparam int ENTRY_W      = 129;
`else
    localparam int ENTRY_W      = 97;
`endif

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - first-word-fall-through trace buffer with exact occupancy level
module trace_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_valid,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_valid = (r_level != '0);
    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rd_ptr];

    // A full buffer still takes a write when the head leaves on the same edge.
    assign w_pop  = i_pop && o_valid;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/cpu_trace_capture.sv
// rtl/cpu_trace_capture.sv - retire-trace capture with drop accounting and self-loop halt detect
// Optional TRACE_TSTAMP_EN: prepend a free-running 32-bit cycle stamp to each entry.
module cpu_trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int HALT_REPEAT = 4,
    parameter int DROP_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     capture_en,
    input  logic                     retire_valid,
    input  logic [31:0]              pc,
    input  logic [31:0]              instr,
    input  logic [31:0]              alu_out,
    input  logic                     regWrite,
    output logic                     tr_valid,
    input  logic                     tr_ready,
    output logic [ENTRY_W-1:0]       tr_data,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int RW = $clog2(HALT_REPEAT + 1);

    logic               r_overflow;
    logic [DROP_W-1:0]  r_drop_cnt;
    logic               r_halted;
    logic               r_pc_valid;
    logic [31:0]        r_pc_prev;
    logic [RW-1:0]      r_rep_cnt;
    logic               w_push_req;
    logic               w_pop;
    logic               w_full;
    logic               w_drop;
    logic               w_same_pc;
    logic [ENTRY_W-1:0] w_entry;

`ifdef TRACE_TSTAMP_EN
    logic [31:0] r_tstamp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tstamp <= '0;
        end else begin
            r_tstamp <= r_tstamp + 32'd1;
        end
    end

    assign w_entry = {r_tstamp, regWrite, pc, instr, alu_out};
`else
    assign w_entry = {regWrite, pc, instr, alu_out};
`endif

    assign w_push_req = capture_en & retire_valid & ~r_halted & ~rst;
    assign w_pop      = tr_valid & tr_ready;
    assign w_drop     = w_push_req & w_full & ~w_pop;
    // pc_prev is meaningless until the first retire after reset has been seen.
    assign w_same_pc  = r_pc_valid && (pc == r_pc_prev);

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push_req),
        .i_wdata (w_entry),
        .i_pop   (tr_ready),
        .o_rdata (tr_data),
        .o_valid (tr_valid),
        .o_full  (w_full),
        .o_level (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted   <= 1'b0;
            r_pc_valid <= 1'b0;
            r_pc_prev  <= '0;
            r_rep_cnt  <= '0;
        end else if (retire_valid) begin
            r_pc_prev  <= pc;
            r_pc_valid <= 1'b1;
            if (w_same_pc) begin
                if (r_rep_cnt != RW'(HALT_REPEAT)) begin
                    r_rep_cnt <= r_rep_cnt + RW'(1);
                end
                if (r_rep_cnt == RW'(HALT_REPEAT - 1)) begin
                    r_halted <= 1'b1;
                end
            end else begin
                r_rep_cnt <= '0;
            end
        end
    end

    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;
    assign halted   = r_halted;

endmodule

// File: tb/tb_cpu_trace_capture.sv
// tb/tb_cpu_trace_capture.sv - self-checking bench for cpu_trace_capture; define TRACE_TSTAMP_EN for the stamped build
`timescale 1ns/1ps
module tb_cpu_trace_capture;
    import trace_pkg::*;

    localparam int DEPTH       = 16;
    localparam int HALT_REPEAT = 4;
    localparam int DROP_W      = 16;
    localparam int LW          = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               capture_en;
    logic               retire_valid;
    logic [31:0]        pc;
    logic [31:0]        instr;
    logic [31:0]        alu_out;
    logic               regWrite;
    logic               tr_valid;
    logic               tr_ready;
    logic [ENTRY_W-1:0] tr_data;
    logic               overflow;
    logic [DROP_W-1:0]  drop_cnt;
    logic               halted;
    logic [LW-1:0]      level;

    cpu_trace_capture #(
        .DEPTH       (DEPTH),
        .HALT_REPEAT (HALT_REPEAT),
        .DROP_W      (DROP_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .capture_en   (capture_en),
        .retire_valid (retire_valid),
        .pc           (pc),
        .instr        (instr),
        .alu_out      (alu_out),
        .regWrite     (regWrite),
        .tr_valid     (tr_valid),
        .tr_ready     (tr_ready),
        .tr_data      (tr_data),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .halted       (halted),
        .level        (level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a queue of entries plus plain counters.
    logic [ENTRY_W-1:0] m_q[$];
    int                 m_drop;
    bit                 m_ovf;
    bit                 m_halt;
    int                 m_run;
    logic [31:0]        m_pc;
`ifdef TRACE_TSTAMP_EN
    logic [31:0]        m_ts;
`endif

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] mk_entry();
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[31:0]  = alu_out;
        e[63:32] = instr;
        e[95:64] = pc;
        e[96]    = regWrite;
`ifdef TRACE_TSTAMP_EN
        e[128:97] = m_ts;
`endif
        return e;
    endfunction

    task automatic model_edge();
        bit do_pop;
        bit push_req;
        if (rst) begin
            m_q.delete();
            m_drop = 0;
            m_ovf  = 0;
            m_halt = 0;
            m_run  = 0;
            m_pc   = '0;
`ifdef TRACE_TSTAMP_EN
            m_ts   = '0;
`endif
        end else begin
            do_pop   = (m_q.size() != 0) && tr_ready;
            push_req = capture_en && retire_valid && !m_halt;
            if (do_pop) void'(m_q.pop_front());
            if (push_req) begin
                if (m_q.size() < DEPTH) m_q.push_back(mk_entry());
                else begin
                    m_ovf = 1;
                    if (m_drop < (2**DROP_W) - 1) m_drop++;
                end
            end
            if (retire_valid) begin
                if (m_run > 0 && pc == m_pc) m_run++;
                else m_run = 1;
                m_pc = pc;
                if (m_run > HALT_REPEAT) m_halt = 1;
            end
`ifdef TRACE_TSTAMP_EN
            m_ts = m_ts + 32'd1;
`endif
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("tr_valid", tr_valid, m_q.size() != 0);
        chk("level", level, m_q.size());
        if (m_q.size() != 0) chk("tr_data", tr_data, m_q[0]);
        chk("overflow", overflow, m_ovf);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("halted", halted, m_halt);
    endtask

    task automatic do_reset();
        rst = 1; capture_en = 0; retire_valid = 0; tr_ready = 0;
        pc = '0; instr = '0; alu_out = '0; regWrite = 0;
        cycle();
        cycle();
        rst = 0;
    endtask

    task automatic drive(input bit rv, input logic [31:0] p, input logic [31:0] a, input bit rdy);
        capture_en   = 1;
        retire_valid = rv;
        pc           = p;
        instr        = ~p;
        alu_out      = a;
        regWrite     = p[2];
        tr_ready     = rdy;
    endtask

    typedef struct {
        bit          rv;
        logic [31:0] p;
        logic [31:0] a;
        bit          exp_valid;
        int          exp_level;
        logic [31:0] exp_pc;
        logic [31:0] exp_alu;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [31:0] rp;

        tbl[0] = '{1, 32'h00, 32'd0, 1, 1, 32'h00, 32'd0};
        tbl[1] = '{1, 32'h04, 32'd1, 1, 1, 32'h04, 32'd1};
        tbl[2] = '{1, 32'h08, 32'd1, 1, 1, 32'h08, 32'd1};
        tbl[3] = '{0, 32'h00, 32'd0, 0, 0, 32'h00, 32'd0};

        // Reset state
        do_reset();
        chk("reset tr_valid", tr_valid, 0);
        chk("reset level", level, 0);
        chk("reset halted", halted, 0);
        chk("reset drop_cnt", drop_cnt, 0);

        // In-order streaming, one cycle latency
        foreach (tbl[i]) begin
            drive(tbl[i].rv, tbl[i].p, tbl[i].a, 1);
            cycle();
            chk("tbl valid", tr_valid, tbl[i].exp_valid);
            chk("tbl level", level, tbl[i].exp_level);
            if (tbl[i].exp_valid) begin
                chk("tbl pc", tr_data[95:64], tbl[i].exp_pc);
                chk("tbl alu", tr_data[31:0], tbl[i].exp_alu);
            end
        end

        // Overflow, then push accepted while full because of a same-cycle pop
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 32'h100 + 32'(4 * i), 32'(i), 0);
            cycle();
        end
        chk("full level", level, 16);
        chk("full drop_cnt", drop_cnt, 4);
        chk("full overflow", overflow, 1);
        drive(1, 32'h200, 32'd99, 1);
        cycle();
        chk("push+pop level", level, 16);
        chk("push+pop drop_cnt", drop_cnt, 4);
        chk("push+pop head pc", tr_data[95:64], 32'h104);

        // Mid-stream reset with 7 buffered entries
        for (int i = 0; i < 9; i++) begin
            drive(0, 32'h0, 32'h0, 1);
            cycle();
        end
        chk("pre-rst level", level, 7);
        do_reset();
        chk("rst level", level, 0);
        chk("rst tr_valid", tr_valid, 0);
        chk("rst overflow", overflow, 0);

        // Self-loop halt: 5 retires at 0x40 captured, later ones ignored
        for (int k = 1; k <= 8; k++) begin
            drive(1, 32'h40, 32'h0, 0);
            cycle();
            if (k == 4) chk("halt after 4", halted, 0);
            if (k == 5) chk("halt after 5", halted, 1);
        end
        chk("halt level", level, 5);
        for (int k = 0; k < 5; k++) begin
            chk("halt drain pc", tr_data[95:64], 32'h40);
            drive(0, 32'h40, 32'h0, 1);
            cycle();
        end
        chk("halt drained", level, 0);
        chk("halt sticky", halted, 1);

`ifdef TRACE_TSTAMP_EN
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive((c == 3) || (c == 7), 32'h300 + 32'(4 * c), 32'(c), 0);
            cycle();
        end
        chk("tstamp first", tr_data[128:97], 32'd3);
        drive(0, 32'h0, 32'h0, 1);
        cycle();
        chk("tstamp second", tr_data[128:97], 32'd7);
`endif

        // Randomized traffic against the model
        do_reset();
        rp = 32'h1000;
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            capture_en   = ($urandom_range(0, 9) != 0);
            retire_valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) >= 4) rp = rp + 32'd4;
            pc           = rp;
            instr        = $urandom;
            alu_out      = $urandom;
            regWrite     = 1'($urandom_range(0, 1));
            tr_ready     = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
